// File: rtl/prefetch_refill_arbiter_if.sv
// ---------------------------------------------------------------------------
// prefetch_refill_arbiter_if
//   Bundles the refill-request side and the prefetch-buffer push/snoop side
//   of the refill arbiter.
//   master : the arbiter (drives req_ready and the push port, samples the rest)
//   slave  : requesters plus prefetch buffer (drive requests, flow-full status
//            and the pop/reinsert snoop, sample grants and pushes)
//   Signals:
//     req_valid / req_data / req_ready   per-flow refill handshake
//     push_valid / push_flow_id / push_data / push_flow_not_full
//                                        push port into the prefetch buffer
//     pop / pop_flow_id / reinsert_valid snoop of the buffer's pop side
// ---------------------------------------------------------------------------
interface prefetch_refill_arbiter_if #(
    parameter int NUM_FLOWS  = 16,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = $clog2(NUM_FLOWS + 1)
);
    logic [NUM_FLOWS-1:0]            req_valid;
    logic [NUM_FLOWS*DATA_WIDTH-1:0] req_data;
    logic [NUM_FLOWS-1:0]            req_ready;

    logic                            push_valid;
    logic [IDX_WIDTH-1:0]            push_flow_id;
    logic [DATA_WIDTH-1:0]           push_data;
    logic                            push_flow_not_full;

    logic                            pop;
    logic [IDX_WIDTH-1:0]            pop_flow_id;
    logic                            reinsert_valid;

    modport master (
        input  req_valid, req_data, push_flow_not_full,
               pop, pop_flow_id, reinsert_valid,
        output req_ready, push_valid, push_flow_id, push_data
    );

    modport slave (
        output req_valid, req_data, push_flow_not_full,
               pop, pop_flow_id, reinsert_valid,
        input  req_ready, push_valid, push_flow_id, push_data
    );
endinterface

// File: rtl/prefetch_refill_arbiter.sv
// ---------------------------------------------------------------------------
// prefetch_refill_arbiter
//   Round-robin arbiter sharing the single push port of the per-flow prefetch
//   buffer among NUM_FLOWS refill requesters. A per-flow credit counter tracks
//   entries resident in the buffer plus the one held in the output stage, so
//   a push can never overflow a flow FIFO. The buffer's pop/reinsert side is
//   snooped to return and consume credits, and a staged push that would
//   collide with a reinsert into the same flow is held back for that cycle
//   (the buffer would otherwise favour the push and drop the reinsert).
//
//   Ports:
//     clk              clock
//     reset_n          asynchronous reset, active low
//     bus              prefetch_refill_arbiter_if.master (request handshake,
//                      push port, pop/reinsert snoop)
//     o__credit_avail  per-flow registered flag: credit counter < DEPTH
//     o__err           sticky flag: credit counter over/underflow seen
// ---------------------------------------------------------------------------
module prefetch_refill_arbiter #(
    parameter int NUM_FLOWS  = 16,
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    prefetch_refill_arbiter_if.master bus,
    output logic [NUM_FLOWS-1:0]     o__credit_avail,
    output logic                     o__err
);

    localparam int IDX_WIDTH = $clog2(NUM_FLOWS + 1);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    // Two extra bits hold DEPTH+2 (two increments) and -1 (pop from zero).
    localparam int SUM_WIDTH = CNT_WIDTH + 2;

    localparam logic [CNT_WIDTH-1:0] DEPTH_C    = CNT_WIDTH'(DEPTH);
    localparam logic [IDX_WIDTH-1:0] LAST_FLOW  = IDX_WIDTH'(NUM_FLOWS - 1);

    // Next credit count for one flow. Returns {error, count}: the error bit is
    // set when the net result leaves [0, DEPTH]; the count is then clamped.
    function automatic logic [CNT_WIDTH:0] credit_next(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc_grant,
        input logic                 inc_reinsert,
        input logic                 dec_pop
    );
        logic [SUM_WIDTH-1:0] sum;
        logic [CNT_WIDTH:0]   res;
        sum = {2'b00, cnt}
            + {{(SUM_WIDTH-1){1'b0}}, inc_grant}
            + {{(SUM_WIDTH-1){1'b0}}, inc_reinsert}
            - {{(SUM_WIDTH-1){1'b0}}, dec_pop};
        if (sum[SUM_WIDTH-1]) begin
            res = {1'b1, {CNT_WIDTH{1'b0}}};
        end else if (sum > SUM_WIDTH'(DEPTH)) begin
            res = {1'b1, DEPTH_C};
        end else begin
            res = {1'b0, sum[CNT_WIDTH-1:0]};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                                stage_valid_q, stage_valid_d;
    logic [IDX_WIDTH-1:0]                stage_flow_q,  stage_flow_d;
    logic [DATA_WIDTH-1:0]               stage_data_q,  stage_data_d;
    logic [IDX_WIDTH-1:0]                ptr_q,         ptr_d;
    logic [NUM_FLOWS-1:0][CNT_WIDTH-1:0] cnt_q,         cnt_d;
    logic [NUM_FLOWS-1:0]                credit_avail_q, credit_avail_d;
    logic                                err_q,         err_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                                hazard_s;
    logic                                push_valid_s;
    logic                                push_fire_s;
    logic                                grant_allowed_s;
    logic [NUM_FLOWS-1:0]                elig_s;
    logic                                grant_found_s;
    logic [IDX_WIDTH-1:0]                grant_idx_s;
    logic [DATA_WIDTH-1:0]               grant_data_s;
    logic                                grant_valid_s;
    logic [NUM_FLOWS-1:0]                grant_vec_s;
    logic [NUM_FLOWS-1:0][CNT_WIDTH:0]   credit_upd_s;
    logic                                err_set_s;

    // Push gating: a reinsert into the staged flow wins this cycle, the push
    // is simply retried next cycle from the unchanged stage.
    always_comb begin
        hazard_s        = bus.reinsert_valid && (bus.pop_flow_id == stage_flow_q);
        push_valid_s    = stage_valid_q && !hazard_s;
        push_fire_s     = push_valid_s && bus.push_flow_not_full;
        grant_allowed_s = !stage_valid_q || push_fire_s;
    end

    // Eligibility: requesting and still holding at least one credit.
    always_comb begin
        elig_s = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            elig_s[f] = bus.req_valid[f] && (cnt_q[f] < DEPTH_C);
        end
    end

    // Round-robin pick: first eligible flow at or above ptr, otherwise the
    // lowest eligible flow (wrap-around).
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (!grant_found_s && elig_s[f] && (IDX_WIDTH'(f) >= ptr_q)) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IDX_WIDTH'(f);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (!grant_found_s && elig_s[f]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IDX_WIDTH'(f);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant vector and data mux for the winning flow.
    always_comb begin
        grant_valid_s = grant_found_s && grant_allowed_s;
        grant_vec_s   = '0;
        grant_data_s  = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (grant_idx_s == IDX_WIDTH'(f)) begin
                grant_vec_s[f] = grant_valid_s;
                grant_data_s   = bus.req_data[f*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                grant_vec_s[f] = 1'b0;
            end
        end
    end

    // Output stage and pointer next state.
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_flow_d  = stage_flow_q;
        stage_data_d  = stage_data_q;
        ptr_d         = ptr_q;
        if (grant_valid_s) begin
            stage_valid_d = 1'b1;
            stage_flow_d  = grant_idx_s;
            stage_data_d  = grant_data_s;
            ptr_d         = (grant_idx_s == LAST_FLOW) ? '0
                                                       : grant_idx_s + IDX_WIDTH'(1);
        end else begin
            // No refill: the stage empties only when its push actually fired.
            stage_valid_d = stage_valid_q && !push_fire_s;
        end
    end

    // Credit counters: net of grant, reinsert and pop applied in one step so
    // simultaneous +1/-1 on the same flow cancel without a transient error.
    always_comb begin
        cnt_d          = cnt_q;
        credit_avail_d = '0;
        credit_upd_s   = '0;
        err_set_s      = 1'b0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            credit_upd_s[f] = credit_next(
                cnt_q[f],
                grant_vec_s[f],
                bus.reinsert_valid && (bus.pop_flow_id == IDX_WIDTH'(f)),
                bus.pop            && (bus.pop_flow_id == IDX_WIDTH'(f)));
            cnt_d[f]          = credit_upd_s[f][CNT_WIDTH-1:0];
            credit_avail_d[f] = (credit_upd_s[f][CNT_WIDTH-1:0] < DEPTH_C);
            err_set_s         = err_set_s | credit_upd_s[f][CNT_WIDTH];
        end
        err_d = err_q | err_set_s;
    end

    // State register; reset drops any staged entry and restores full credit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid_q  <= 1'b0;
            stage_flow_q   <= '0;
            stage_data_q   <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            credit_avail_q <= '1;
            err_q          <= 1'b0;
        end else begin
            stage_valid_q  <= stage_valid_d;
            stage_flow_q   <= stage_flow_d;
            stage_data_q   <= stage_data_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            credit_avail_q <= credit_avail_d;
            err_q          <= err_d;
        end
    end

    // Output drive.
    assign bus.req_ready     = grant_vec_s;
    assign bus.push_valid    = push_valid_s;
    assign bus.push_flow_id  = stage_flow_q;
    assign bus.push_data     = stage_data_q;
    assign o__credit_avail   = credit_avail_q;
    assign o__err            = err_q;

endmodule

// File: tb/tb_prefetch_refill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prefetch_refill_arbiter
//   Directed bench for prefetch_refill_arbiter. Instance u_dut1 (DEPTH=1)
//   has its pushes checked by a scoreboard queue filled by the stimulus;
//   instance u_dut2 (DEPTH=2) covers the cancelling grant+pop update, the
//   sticky underflow error and the asynchronous reset.
// ---------------------------------------------------------------------------
module tb_prefetch_refill_arbiter;

    localparam int NF = 16;
    localparam int DW = 8;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    prefetch_refill_arbiter_if #(.NUM_FLOWS(NF), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus1 ();
    prefetch_refill_arbiter_if #(.NUM_FLOWS(NF), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus2 ();

    logic [NF-1:0] credit1, credit2;
    logic          err1, err2;

    prefetch_refill_arbiter #(.NUM_FLOWS(NF), .DEPTH(1), .DATA_WIDTH(DW)) u_dut1 (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus1),
        .o__credit_avail (credit1),
        .o__err          (err1)
    );

    prefetch_refill_arbiter #(.NUM_FLOWS(NF), .DEPTH(2), .DATA_WIDTH(DW)) u_dut2 (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus2),
        .o__credit_avail (credit2),
        .o__err          (err2)
    );

    int checks   = 0;
    int failures = 0;

    logic [IW+DW-1:0] exp_q [$];
    logic [IW+DW-1:0] exp_e;
    logic [NF-1:0]    oh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted push of u_dut1 must match the oldest
    // expected {flow, data}.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus1.push_valid === 1'b1 && bus1.push_flow_not_full === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_push actual=%0h required=none",
                         {bus1.push_flow_id, bus1.push_data});
            end else begin
                exp_e = exp_q.pop_front();
                chk("sb_push", 32'({bus1.push_flow_id, bus1.push_data}), 32'(exp_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.req_valid = '0; bus1.req_data = '0; bus1.push_flow_not_full = 1'b1;
        bus1.pop = 1'b0; bus1.pop_flow_id = '0; bus1.reinsert_valid = 1'b0;
        bus2.req_valid = '0; bus2.req_data = '0; bus2.push_flow_not_full = 1'b1;
        bus2.pop = 1'b0; bus2.pop_flow_id = '0; bus2.reinsert_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();

        // Reset values.
        chk("rst_push_valid", 32'(bus1.push_valid), 32'h0);
        chk("rst_flow_data",  32'({bus1.push_flow_id, bus1.push_data}), 32'h0);
        chk("rst_credit",     32'(credit1), 32'h0000FFFF);
        chk("rst_err",        32'(err1), 32'h0);
        reset_n = 1'b1;
        tick();

        // 1) single request on flow 0, credit limit of one entry.
        bus1.req_valid = 16'h0001;
        bus1.req_data[7:0] = 8'h2A;
        #1;
        chk("t1_ready_t0", 32'(bus1.req_ready), 32'h0001);
        exp_q.push_back({5'd0, 8'h2A});
        tick();
        chk("t1_push_valid_t1", 32'(bus1.push_valid), 32'h1);
        chk("t1_ready_no_credit", 32'(bus1.req_ready), 32'h0);
        chk("t1_credit0", 32'(credit1[0]), 32'h0);
        tick();
        chk("t1_ready_still_blocked", 32'(bus1.req_ready), 32'h0);
        bus1.pop = 1'b1; bus1.pop_flow_id = 5'd0;
        tick();
        bus1.pop = 1'b0;
        #1;
        chk("t1_ready_after_pop", 32'(bus1.req_ready), 32'h0001);
        exp_q.push_back({5'd0, 8'h2A});
        tick();
        bus1.req_valid = '0;
        bus1.pop = 1'b1; bus1.pop_flow_id = 5'd0;
        tick();
        bus1.pop = 1'b0;

        // 2) all flows requesting, credits returned every cycle.
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int f = 0; f < NF; f++) bus1.req_data[f*DW +: DW] = DW'(8'h10 + f);
        bus1.req_valid = '1;
        for (int k = 0; k <= NF; k++) begin
            if (k > 0) begin
                bus1.pop = 1'b1;
                bus1.pop_flow_id = IW'((k - 1) % NF);
            end
            #1;
            oh = NF'(1) << (k % NF);
            chk("t2_rr_grant", 32'(bus1.req_ready), 32'(oh));
            if (k > 0) chk("t2_back_to_back", 32'(bus1.push_valid), 32'h1);
            exp_q.push_back({IW'(k % NF), DW'(8'h10 + (k % NF))});
            tick();
        end
        bus1.req_valid = '0;
        bus1.pop = 1'b1; bus1.pop_flow_id = 5'd0;
        #1;
        chk("t2_last_push", 32'(bus1.push_valid), 32'h1);
        tick();
        bus1.pop = 1'b0;

        // 3) reinsert into the staged flow blocks the push for one cycle.
        bus1.req_valid = 16'h0020;
        bus1.req_data[5*DW +: DW] = 8'h55;
        #1;
        chk("t3_ready", 32'(bus1.req_ready), 32'h0020);
        exp_q.push_back({5'd5, 8'h55});
        tick();
        bus1.req_valid = '0;
        bus1.reinsert_valid = 1'b1; bus1.pop = 1'b1; bus1.pop_flow_id = 5'd5;
        #1;
        chk("t3_hazard_gate", 32'(bus1.push_valid), 32'h0);
        tick();
        bus1.reinsert_valid = 1'b0; bus1.pop = 1'b0;
        #1;
        chk("t3_push_after", 32'(bus1.push_valid), 32'h1);
        chk("t3_data_unchanged", 32'({bus1.push_flow_id, bus1.push_data}), 32'({5'd5, 8'h55}));
        tick();
        bus1.pop = 1'b1; bus1.pop_flow_id = 5'd5;
        tick();
        bus1.pop = 1'b0;

        // 4) buffer backpressure for three cycles.
        bus1.req_valid = 16'h0080;
        bus1.req_data[7*DW +: DW] = 8'h77;
        #1;
        chk("t4_ready", 32'(bus1.req_ready), 32'h0080);
        exp_q.push_back({5'd7, 8'h77});
        tick();
        bus1.req_valid = 16'h0100;
        bus1.req_data[8*DW +: DW] = 8'h88;
        bus1.push_flow_not_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t4_hold_valid", 32'(bus1.push_valid), 32'h1);
            chk("t4_hold_data",  32'(bus1.push_data), 32'h77);
            chk("t4_ready_zero", 32'(bus1.req_ready), 32'h0);
            tick();
        end
        bus1.push_flow_not_full = 1'b1;
        #1;
        chk("t4_fire_ready", 32'(bus1.req_ready), 32'h0100);
        exp_q.push_back({5'd8, 8'h88});
        tick();
        bus1.req_valid = '0;
        tick();
        tick();

        // 5) DEPTH=2: grant and pop on flow 3 in one cycle, then underflow.
        bus2.req_valid = 16'h0008;
        bus2.req_data[3*DW +: DW] = 8'h33;
        #1;
        chk("t5_grant_a", 32'(bus2.req_ready), 32'h0008);
        tick();
        bus2.pop = 1'b1; bus2.pop_flow_id = 5'd3;
        #1;
        chk("t5_grant_b", 32'(bus2.req_ready), 32'h0008);
        tick();
        bus2.req_valid = '0;
        #1;
        chk("t5_cnt_unchanged", 32'(credit2[3]), 32'h1);
        chk("t5_no_err", 32'(err2), 32'h0);
        tick();
        #1;
        chk("t5_no_err_before_underflow", 32'(err2), 32'h0);
        tick();
        bus2.pop = 1'b0;
        #1;
        chk("t5_err_set", 32'(err2), 32'h1);
        tick();
        chk("t5_err_sticky", 32'(err2), 32'h1);

        // 6) asynchronous reset with a full stage and cnt3 == DEPTH.
        bus2.req_valid = 16'h0008;
        #1;
        chk("t6_grant1", 32'(bus2.req_ready), 32'h0008);
        tick();
        #1;
        chk("t6_grant2", 32'(bus2.req_ready), 32'h0008);
        tick();
        bus2.req_valid = '0;
        bus2.push_flow_not_full = 1'b0;
        #1;
        chk("t6_stage_full", 32'(bus2.push_valid), 32'h1);
        chk("t6_cnt_full", 32'(credit2[3]), 32'h0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_async_push_valid", 32'(bus2.push_valid), 32'h0);
        chk("t6_async_flow_data", 32'({bus2.push_flow_id, bus2.push_data}), 32'h0);
        chk("t6_async_err", 32'(err2), 32'h0);
        chk("t6_async_credit", 32'(credit2), 32'h0000FFFF);
        tick();
        tick();
        reset_n = 1'b1;
        bus2.push_flow_not_full = 1'b1;
        #1;
        chk("t6_no_stale_push", 32'(bus2.push_valid), 32'h0);
        bus2.req_valid = 16'h0011;
        #1;
        chk("t6_ptr_zero", 32'(bus2.req_ready), 32'h0001);
        tick();
        bus2.req_valid = '0;
        tick();

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
